// File: rtl/umstr_arb_pkg.sv
// Shared types and helpers for the UDP master stream arbiters.
package umstr_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Increment with an explicit wrap at n, so port counts need not be powers of two.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/umstr_rr_pick.sv
// Round-robin pick: finds the first request at or after prio, wrapping at N_PORTS.
module umstr_rr_pick
    import umstr_arb_pkg::*;
#(
    parameter  int N_PORTS = 4,
    localparam int GRANT_W = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [GRANT_W-1:0] prio,
    output logic               found,
    output logic [GRANT_W-1:0] index
);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 32'(prio);
        for (int i = 0; i < N_PORTS; i++) begin
            if (!found && req[GRANT_W'(cand)]) begin
                found = 1'b1;
                index = GRANT_W'(cand);
            end
            cand = rr_next(cand, N_PORTS);
        end
    end

endmodule

// File: rtl/umstr_axis_rr_arbiter.sv
// Packet-level round-robin merge of N_PORTS AXI-Stream sources; a grant lasts a whole packet.
//
// state    | meaning
// ARB_IDLE | no packet in flight, arbitrating among valid ports
// ARB_BUSY | passing the granted port through until its last beat is accepted
module umstr_axis_rr_arbiter
    import umstr_arb_pkg::*;
#(
    parameter  int T_DATA_WIDTH = 32,
    parameter  int N_PORTS      = 4,
    localparam int GRANT_W      = $clog2(N_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_PORTS*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [N_PORTS-1:0]              s_last_i,
    input  logic [N_PORTS-1:0]              s_valid_i,
    output logic [N_PORTS-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]         m_data_o,
    output logic                            m_last_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [GRANT_W-1:0]              grant_o,
    output logic                            busy_o
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [GRANT_W-1:0] grant;
    logic [GRANT_W-1:0] prio;
    logic               pick_found;
    logic [GRANT_W-1:0] pick_index;
    logic               pkt_done;

    umstr_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req   (s_valid_i),
        .prio  (prio),
        .found (pick_found),
        .index (pick_index)
    );

    assign m_data_o = s_data_i[grant*T_DATA_WIDTH +: T_DATA_WIDTH];
    assign m_last_o = s_last_i[grant];
    assign pkt_done = (state == ARB_BUSY) && s_valid_i[grant] && m_ready_i && s_last_i[grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            grant <= '0;
            prio  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_found) begin
                grant <= pick_index;
            end
            if (pkt_done) begin
                prio <= GRANT_W'(rr_next(32'(grant), N_PORTS));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (pick_found) state_nxt = ARB_BUSY;
            ARB_BUSY: if (pkt_done) state_nxt = ARB_IDLE;
        endcase
    end

    // Grant is held through source bubbles; only the last-beat handshake releases it.
    always_comb begin
        s_ready_o = '0;
        m_valid_o = 1'b0;
        if (state == ARB_BUSY) begin
            s_ready_o[grant] = m_ready_i;
            m_valid_o        = s_valid_i[grant];
        end
    end

    assign busy_o  = (state == ARB_BUSY);
    assign grant_o = grant;

endmodule

// File: tb/tb_umstr_axis_rr_arbiter.sv
// Self-checking bench: per-port beat scoreboard on a 4-port arbiter, vector table on a 3-port one.
module tb_umstr_axis_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [127:0] s_data4  = '0;
    logic [3:0]   s_last4  = '0;
    logic [3:0]   s_valid4 = '0;
    logic [3:0]   s_ready4;
    logic [31:0]  m_data4;
    logic         m_last4;
    logic         m_valid4;
    logic         m_ready4 = 1'b1;
    logic [1:0]   grant4;
    logic         busy4;

    logic [23:0]  s_data3  = 24'h221100;
    logic [2:0]   s_last3  = '0;
    logic [2:0]   s_valid3 = '0;
    logic [2:0]   s_ready3;
    logic [7:0]   m_data3;
    logic         m_last3;
    logic         m_valid3;
    logic         m_ready3 = 1'b1;
    logic [1:0]   grant3;
    logic         busy3;

    umstr_axis_rr_arbiter #(.T_DATA_WIDTH(32), .N_PORTS(4)) dut4 (
        .clk(clk), .reset(rst),
        .s_data_i(s_data4), .s_last_i(s_last4), .s_valid_i(s_valid4), .s_ready_o(s_ready4),
        .m_data_o(m_data4), .m_last_o(m_last4), .m_valid_o(m_valid4), .m_ready_i(m_ready4),
        .grant_o(grant4), .busy_o(busy4)
    );

    umstr_axis_rr_arbiter #(.T_DATA_WIDTH(8), .N_PORTS(3)) dut3 (
        .clk(clk), .reset(rst),
        .s_data_i(s_data3), .s_last_i(s_last3), .s_valid_i(s_valid3), .s_ready_o(s_ready3),
        .m_data_o(m_data3), .m_last_o(m_last3), .m_valid_o(m_valid3), .m_ready_i(m_ready3),
        .grant_o(grant3), .busy_o(busy3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [2:0] valid;
        logic [2:0] last;
        logic       busy;
        logic [1:0] grant;
        logic [2:0] sready;
    } vec3_t;

    beat_t       src[4][$];
    beat_t       expq[4][$];
    beat_t       mon_b;
    logic [31:0] fifo_q[$];
    logic [31:0] drain_exp[$];
    int          order_q[$];
    int          last_cyc[$];
    vec3_t       vecs[7];

    logic [3:0]  en = 4'hF;
    logic [3:0]  take4 = '0;
    logic        take_m = 1'b0;
    logic [31:0] cap_data = '0;
    bit          fifo_mode = 0;
    bit          rd_en = 0;
    int          hs_count = 0;
    int          cyc = 0;
    int          drained = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_total();
        int t = 0;
        for (int k = 0; k < 4; k++) t += expq[k].size();
        return t;
    endfunction

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src[k].size() > 0) begin
                s_valid4[k]          = en[k];
                s_data4[k*32 +: 32]  = src[k][0].data;
                s_last4[k]           = src[k][0].last;
            end else begin
                s_valid4[k] = 1'b0;
                s_last4[k]  = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int port, input int n, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 32'(i);
            b.last = (i == n - 1);
            src[port].push_back(b);
            expq[port].push_back(b);
            if (fifo_mode) drain_exp.push_back(b.data);
        end
        drive();
    endtask

    task automatic step();
        logic [31:0] d;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (take4[k] && src[k].size() > 0) void'(src[k].pop_front());
        if (fifo_mode) begin
            if (take_m) fifo_q.push_back(cap_data);
            if (rd_en && fifo_q.size() > 0) begin
                d = fifo_q.pop_front();
                drained++;
                if (drain_exp.size() > 0) chk("fifo_drain_order", d, drain_exp.pop_front());
                else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fifo_extra_beat: got %0h, expected none", d);
                end
            end
            m_ready4 = (fifo_q.size() < 4);
        end
        drive();
        #1;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_total() > 0 || drain_exp.size() > 0) && n < bound) begin
            step();
            n++;
        end
        chk("drain_pending", exp_total() + drain_exp.size(), 0);
    endtask

    task automatic flush_all();
        for (int k = 0; k < 4; k++) begin
            src[k].delete();
            expq[k].delete();
        end
        fifo_q.delete();
        drain_exp.delete();
        order_q.delete();
        last_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_all();
        fifo_mode = 0;
        rd_en     = 0;
        en        = 4'hF;
        m_ready4  = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic chk_order2(input string name, input int a, input int b);
        chk({name, "_len"}, order_q.size(), 2);
        if (order_q.size() >= 2) begin
            chk({name, "_0"}, order_q[0], a);
            chk({name, "_1"}, order_q[1], b);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every accepted output beat must be the next expected beat of the granted port.
    initial forever begin
        @(negedge clk);
        take4    = s_ready4 & s_valid4;
        take_m   = m_valid4 & m_ready4;
        cap_data = m_data4;
        if (!rst && take_m) begin
            hs_count++;
            if (expq[grant4].size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h on port %0d, expected none", m_data4, grant4);
            end else begin
                mon_b = expq[grant4].pop_front();
                chk("beat_data", m_data4, mon_b.data);
                chk("beat_last", m_last4, mon_b.last);
            end
            if (m_last4) begin
                order_q.push_back(int'(grant4));
                last_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        // 3-port: port 2 served, then 0 and 2 request; prio wraps 2 -> 0, never 3
        vecs[0] = '{3'b100, 3'b100, 1'b0, 2'd0, 3'b000};
        vecs[1] = '{3'b100, 3'b100, 1'b1, 2'd2, 3'b100};
        vecs[2] = '{3'b101, 3'b101, 1'b0, 2'd2, 3'b000};
        vecs[3] = '{3'b101, 3'b101, 1'b1, 2'd0, 3'b001};
        vecs[4] = '{3'b100, 3'b100, 1'b0, 2'd0, 3'b000};
        vecs[5] = '{3'b100, 3'b100, 1'b1, 2'd2, 3'b100};
        vecs[6] = '{3'b000, 3'b000, 1'b0, 2'd2, 3'b000};

        rst = 1'b1;
        #12;
        chk("rst_busy", busy4, 0);
        chk("rst_mvalid", m_valid4, 0);
        chk("rst_sready", s_ready4, 0);
        chk("rst_grant", grant4, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            s_valid3 = vecs[i].valid;
            s_last3  = vecs[i].last;
            #1;
            chk($sformatf("n3_busy_%0d", i), busy3, vecs[i].busy);
            chk($sformatf("n3_grant_%0d", i), grant3, vecs[i].grant);
            chk($sformatf("n3_sready_%0d", i), s_ready3, vecs[i].sready);
            chk($sformatf("n3_mvalid_%0d", i), m_valid3, vecs[i].sready != 0);
            chk($sformatf("n3_grant_range_%0d", i), grant3 < 2'd3, 1);
        end

        // basic handoff: port 2, three beats
        do_reset();
        load_pkt(2, 3, 32'hA0);
        chk("hand_busy_pre", busy4, 0);
        step();
        chk("hand_busy", busy4, 1);
        chk("hand_grant", grant4, 2);
        chk("hand_sready", s_ready4, 4'b0100);
        step();
        step();
        step();
        chk("hand_idle_after", busy4, 0);
        // prio now 3: simultaneous 0 and 3 must serve 3 first
        load_pkt(0, 1, 32'hB0);
        load_pkt(3, 1, 32'hB3);
        wait_drain(20);
        chk("hand_order_len", order_q.size(), 3);
        if (order_q.size() == 3) begin
            chk("hand_order_0", order_q[0], 2);
            chk("hand_order_1", order_q[1], 3);
            chk("hand_order_2", order_q[2], 0);
        end

        // rotation: all ports continuously requesting single-beat packets
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load_pkt(k, 1, 32'hC0 + 32'(k * 16));
            load_pkt(k, 1, 32'hC1 + 32'(k * 16));
        end
        wait_drain(40);
        chk("rot_len", order_q.size(), 8);
        if (order_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("rot_order_%0d", i), order_q[i], i % 4);
            for (int i = 1; i < 8; i++) chk($sformatf("rot_gap_%0d", i), last_cyc[i] - last_cyc[i-1], 2);
        end

        // back-pressure: ready toggles during a 4-beat packet from port 1
        do_reset();
        load_pkt(1, 4, 32'hD0);
        step();
        load_pkt(0, 1, 32'hE0);
        for (int i = 0; i < 7; i++) begin
            m_ready4 = (i % 2 == 0);
            #1;
            chk($sformatf("bp_sready1_%0d", i), s_ready4[1], m_ready4);
            chk($sformatf("bp_sready0_%0d", i), s_ready4[0], 0);
            chk($sformatf("bp_grant_%0d", i), grant4, 1);
            step();
        end
        chk("bp_idle_after", busy4, 0);
        m_ready4 = 1'b1;
        wait_drain(20);
        chk_order2("bp_order", 1, 0);

        // bubble: port 1 valid drops two cycles mid-packet
        do_reset();
        load_pkt(1, 4, 32'hF0);
        step();
        load_pkt(0, 1, 32'hE8);
        en[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("bub_mvalid_%0d", i), m_valid4, 0);
            chk($sformatf("bub_busy_%0d", i), busy4, 1);
            chk($sformatf("bub_grant_%0d", i), grant4, 1);
            chk($sformatf("bub_sready0_%0d", i), s_ready4[0], 0);
        end
        en[1] = 1'b1;
        step();
        wait_drain(30);
        chk_order2("bub_order", 1, 0);

        // reset mid-packet: prio was 3, must restart from 0
        do_reset();
        load_pkt(2, 1, 32'h10);
        wait_drain(10);
        load_pkt(2, 5, 32'h20);
        step();
        step();
        chk("mid_busy_pre", busy4, 1);
        rst = 1'b1;
        #1;
        chk("mid_mvalid", m_valid4, 0);
        chk("mid_sready", s_ready4, 0);
        chk("mid_busy", busy4, 0);
        flush_all();
        drive();
        step();
        rst = 1'b0;
        #1;
        load_pkt(0, 1, 32'h30);
        load_pkt(3, 1, 32'h33);
        wait_drain(20);
        chk_order2("mid_order", 0, 3);

        // 4-deep FIFO downstream with its read side stalled, then released
        do_reset();
        fifo_mode = 1;
        drained   = 0;
        hs_count  = 0;
        load_pkt(3, 6, 32'h40);
        repeat (12) step();
        chk("fifo_held_beats", hs_count, 4);
        chk("fifo_held_mvalid", m_valid4, 1);
        chk("fifo_held_sready", s_ready4[3], 0);
        chk("fifo_held_busy", busy4, 1);
        rd_en = 1;
        wait_drain(40);
        chk("fifo_drained", drained, 6);
        chk("fifo_empty", fifo_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
